// File: rtl/parking_exit.sv
// Exit-gate controller: password-checked barrier with occupancy tracking and bad-code lockout.
// All outputs are registered and respond one cycle after the inputs that cause them; there is no backpressure.
module parking_exit #(
    parameter logic [31:0] EXIT_CODE = 32'd2468,
    parameter int unsigned CAPACITY  = 10,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        car,
    input  logic        f_sen,
    input  logic        b_sen,
    input  logic [31:0] psd,
    input  logic        psd_vld,
    input  logic        entry_ok,
    output logic        gate,
    output logic        e,
    output logic        alarm,
    output logic [7:0]  count,
    output logic        full,
    output logic        empty
);

    typedef enum logic [1:0] {IDLE, CHECK, OPEN, LOCK} state_t;

    localparam logic [7:0] CAP   = 8'(CAPACITY);
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] count_q, count_d;
    logic [1:0] attempts_q, attempts_d;
    logic       gate_q, gate_d;
    logic       e_q, e_d;
    logic       alarm_q, alarm_d;
    logic       code_ok, code_bad, expired, exit_go;

    assign code_ok  = psd_vld && (psd == EXIT_CODE);
    assign code_bad = psd_vld && (psd != EXIT_CODE);
    assign expired  = (timer_q == TLAST);

    always_comb begin
        state_d    = state_q;
        attempts_d = attempts_q;
        alarm_d    = 1'b0;
        exit_go    = 1'b0;
        if (!car) begin
            state_d    = IDLE;
            attempts_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (f_sen) begin
                        if (count_q != 8'd0) begin
                            state_d    = CHECK;
                            attempts_d = 2'd0;
                        end else begin
                            alarm_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (code_ok) begin
                        state_d = OPEN;
                    end else begin
                        if (code_bad) begin
                            attempts_d = attempts_q + 2'd1;
                        end
                        // A third bad code outranks a coincident timeout
                        if (code_bad && (attempts_q == 2'd2)) begin
                            state_d = LOCK;
                        end else if (expired) begin
                            state_d    = IDLE;
                            attempts_d = 2'd0;
                        end
                    end
                end
                OPEN: begin
                    if (b_sen) begin
                        state_d = IDLE;
                        exit_go = 1'b1;
                    end else if (expired) begin
                        state_d = IDLE;
                    end
                end
                LOCK:    state_d = LOCK;
                default: state_d = IDLE;
            endcase
        end

        gate_d  = (state_d == OPEN);
        alarm_d = alarm_d || (state_d == LOCK);
        e_d     = exit_go && (count_q != 8'd0);

        if (state_d != state_q) begin
            timer_d = 8'd0;
        end else if (timer_q == 8'hFF) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 8'd1;
        end

        // An admission coinciding with an exit leaves occupancy unchanged
        count_d = count_q;
        if (e_d && !entry_ok) begin
            count_d = count_q - 8'd1;
        end else if (!e_d && entry_ok && (count_q < CAP)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= 8'd0;
            count_q    <= 8'd0;
            attempts_q <= 2'd0;
            gate_q     <= 1'b0;
            e_q        <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            attempts_q <= attempts_d;
            gate_q     <= gate_d;
            e_q        <= e_d;
            alarm_q    <= alarm_d;
        end
    end

    assign gate  = gate_q;
    assign e     = e_q;
    assign alarm = alarm_q;
    assign count = count_q;
    assign full  = (count_q == CAP);
    assign empty = (count_q == 8'd0);

endmodule

// File: tb/tb_parking_exit.sv
// Bench for parking_exit: directed scenarios plus random traffic against a rule-level model.
module tb_parking_exit;

    localparam logic [31:0] CODE = 32'd2468;
    localparam int          CAP  = 10;
    localparam int          TMO  = 16;

    logic        clk = 1'b0;
    logic        rst_n, car, f_sen, b_sen, psd_vld, entry_ok;
    logic [31:0] psd;
    logic        gate, e, alarm, full, empty;
    logic [7:0]  count;

    int total = 0;
    int bad   = 0;

    typedef enum {M_IDLE, M_CHECK, M_OPEN, M_LOCK} mmode_t;
    mmode_t m_mode = M_IDLE;
    int     m_age = 0, m_bad = 0, m_count = 0;
    bit     m_gate = 0, m_e = 0, m_alarm = 0;

    always #5 clk = ~clk;

    parking_exit #(.EXIT_CODE(CODE), .CAPACITY(CAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .car(car), .f_sen(f_sen), .b_sen(b_sen),
        .psd(psd), .psd_vld(psd_vld), .entry_ok(entry_ok),
        .gate(gate), .e(e), .alarm(alarm), .count(count), .full(full), .empty(empty)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Applies the exit-gate rules to the inputs currently driven, one clock's worth
    task automatic model_step();
        int old_count;
        bit leaving;
        if (!rst_n) begin
            m_mode = M_IDLE; m_age = 0; m_bad = 0; m_count = 0;
            m_gate = 0; m_e = 0; m_alarm = 0;
        end else begin
            old_count = m_count;
            leaving   = car && (m_mode == M_OPEN) && b_sen;
            m_e       = leaving;
            if (leaving && !entry_ok) m_count = m_count - 1;
            else if (!leaving && entry_ok && m_count < CAP) m_count = m_count + 1;
            m_alarm = 0;
            if (!car) begin
                m_mode = M_IDLE; m_age = 0; m_bad = 0;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        if (f_sen && old_count > 0) begin
                            m_mode = M_CHECK; m_age = 0; m_bad = 0;
                        end else if (f_sen) begin
                            m_alarm = 1;
                        end
                    end
                    M_CHECK: begin
                        if (psd_vld && psd == CODE) begin
                            m_mode = M_OPEN; m_age = 0;
                        end else begin
                            if (psd_vld) m_bad = m_bad + 1;
                            if (m_bad >= 3) begin
                                m_mode = M_LOCK; m_age = 0;
                            end else if (m_age + 1 >= TMO) begin
                                m_mode = M_IDLE; m_age = 0; m_bad = 0;
                            end else begin
                                m_age = m_age + 1;
                            end
                        end
                    end
                    M_OPEN: begin
                        if (b_sen || m_age + 1 >= TMO) begin
                            m_mode = M_IDLE; m_age = 0;
                        end else begin
                            m_age = m_age + 1;
                        end
                    end
                    default: m_mode = M_LOCK;
                endcase
            end
            m_gate  = (m_mode == M_OPEN);
            m_alarm = m_alarm || (m_mode == M_LOCK);
        end
    endtask

    task automatic step(input bit r, input bit c, input bit f, input bit b,
                        input bit v, input bit en, input logic [31:0] p);
        @(negedge clk);
        rst_n = r; car = c; f_sen = f; b_sen = b; psd_vld = v; entry_ok = en; psd = p;
        model_step();
        @(posedge clk);
        #1;
        chk("gate",  32'(gate),  32'(m_gate));
        chk("e",     32'(e),     32'(m_e));
        chk("alarm", 32'(alarm), 32'(m_alarm));
        chk("count", 32'(count), 32'(m_count));
        chk("full",  32'(full),  32'(m_count == CAP));
        chk("empty", 32'(empty), 32'(m_count == 0));
    endtask

    task automatic idle_step();
        step(1, 1, 0, 0, 0, 0, 32'd0);
    endtask

    task automatic do_reset();
        step(0, 1, 0, 0, 0, 0, 32'd0);
    endtask

    task automatic admit(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 1, 32'd0);
    endtask

    task automatic open_gate();
        step(1, 1, 1, 0, 0, 0, 32'd0);
        step(1, 1, 0, 0, 1, 0, CODE);
    endtask

    initial begin
        rst_n = 0; car = 0; f_sen = 0; b_sen = 0; psd_vld = 0; entry_ok = 0; psd = '0;

        do_reset();
        chk("rst_gate",  32'(gate),  0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);

        // three admissions, password, exit
        admit(3);
        open_gate();
        chk("r037_gate", 32'(gate), 1);
        idle_step();
        step(1, 1, 0, 1, 0, 0, 32'd0);
        chk("r037_e",     32'(e),     1);
        chk("r037_count", 32'(count), 2);
        chk("r037_gate0", 32'(gate),  0);
        idle_step();
        chk("r037_e_off", 32'(e), 0);

        // three bad codes lock, car=0 releases
        step(1, 1, 1, 0, 0, 0, 32'd0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 0, 32'd1111);
        chk("r038_alarm", 32'(alarm), 1);
        chk("r038_gate",  32'(gate),  0);
        step(1, 1, 0, 1, 1, 0, CODE);
        chk("r038_held",  32'(alarm), 1);
        step(1, 0, 0, 0, 0, 0, 32'd0);
        chk("r038_clear", 32'(alarm), 0);
        chk("r038_count", 32'(count), 2);
        idle_step();

        // empty lot exit request, then fill past capacity
        do_reset();
        step(1, 1, 1, 0, 0, 0, 32'd0);
        step(1, 1, 1, 0, 1, 0, CODE);
        chk("r039_alarm", 32'(alarm), 1);
        chk("r039_gate",  32'(gate),  0);
        idle_step();
        chk("r039_alarm0", 32'(alarm), 0);
        admit(12);
        chk("r039_count", 32'(count), 10);
        chk("r039_full",  32'(full),  1);

        // OPEN timeout
        open_gate();
        for (int i = 0; i < TMO - 1; i++) idle_step();
        chk("r040_gate_hold", 32'(gate), 1);
        idle_step();
        chk("r040_gate",  32'(gate),  0);
        chk("r040_count", 32'(count), 10);
        chk("r040_e",     32'(e),     0);

        // admission coincident with exit
        do_reset();
        admit(5);
        open_gate();
        step(1, 1, 0, 1, 0, 1, 32'd0);
        chk("r041_count", 32'(count), 5);
        chk("r041_e",     32'(e),     1);

        // reset mid-OPEN
        do_reset();
        admit(4);
        open_gate();
        chk("r042_open", 32'(gate), 1);
        step(0, 1, 0, 1, 0, 1, 32'd0);
        chk("r042_gate",  32'(gate),  0);
        chk("r042_count", 32'(count), 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 29) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 2) == 0) ? CODE : $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
